// File: rtl/logic_sweep_pkg.sv
// Shared types for the logic_sweep slice: function-select codes and FSM states.
package logic_sweep_pkg;

  typedef enum logic [2:0] {
    F_AND  = 3'd0,
    F_OR   = 3'd1,
    F_INH  = 3'd2,
    F_XOR  = 3'd3,
    F_NAND = 3'd4,
    F_NOR  = 3'd5,
    F_XNOR = 3'd6,
    F_ANDN = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_sweep_core.sv
// Bitwise two-operand evaluator: direct gate path plus an optional NAND-only path.
// The NAND-only path exists only when LOGIC_SWEEP_CHECK_EN is defined.
module logic_sweep_core
  import logic_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  func_t            func,
  output logic [WIDTH-1:0] s_gate,
  output logic [WIDTH-1:0] s_expr
);

  always_comb begin
    s_gate = '0;
    case (func)
      F_AND:   s_gate = a & b;
      F_OR:    s_gate = a | b;
      F_INH:   s_gate = ~a & b;
      F_XOR:   s_gate = a ^ b;
      F_NAND:  s_gate = ~(a & b);
      F_NOR:   s_gate = ~(a | b);
      F_XNOR:  s_gate = ~(a ^ b);
      F_ANDN:  s_gate = a & ~b;
      default: s_gate = '0;
    endcase
  end

`ifdef LOGIC_SWEEP_CHECK_EN
  function automatic logic [WIDTH-1:0] nd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  logic [WIDTH-1:0] nab, na, nb, t_and, t_or, t_xor, t_inh, t_andn;

  // Every function rebuilt from two-input NANDs only
  always_comb begin
    nab    = nd(a, b);
    na     = nd(a, a);
    nb     = nd(b, b);
    t_and  = nd(nab, nab);
    t_or   = nd(na, nb);
    t_xor  = nd(nd(a, nab), nd(b, nab));
    t_inh  = nd(nd(na, b), nd(na, b));
    t_andn = nd(nd(a, nb), nd(a, nb));
    s_expr = '0;
    case (func)
      F_AND:   s_expr = t_and;
      F_OR:    s_expr = t_or;
      F_INH:   s_expr = t_inh;
      F_XOR:   s_expr = t_xor;
      F_NAND:  s_expr = nab;
      F_NOR:   s_expr = nd(t_or, t_or);
      F_XNOR:  s_expr = nd(t_xor, t_xor);
      F_ANDN:  s_expr = t_andn;
      default: s_expr = '0;
    endcase
  end
`else
  assign s_expr = '0;
`endif

endmodule

// File: rtl/logic_sweep.sv
// Sweeps all (a,b) operand pairs through a selected bitwise function over valid/ready.
// LOGIC_SWEEP_CHECK_EN adds a cross-check path driving mismatch and err_count.
module logic_sweep
  import logic_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       func,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_s,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MW = 2 * WIDTH;

  state_t           state, state_d;
  func_t            func_q, func_d;
  logic [MW-1:0]    m, m_d;
  logic [WIDTH-1:0] a_d, b_d, s_d, s_gate, s_expr;
  logic [CNT_W-1:0] err_d;
  logic             valid_d, done_d, busy_d, mis_d, mis_c, load;

  assign a_d = m_d[MW-1:WIDTH];
  assign b_d = m_d[WIDTH-1:0];

  logic_sweep_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_d),
    .b      (b_d),
    .func   (func_d),
    .s_gate (s_gate),
    .s_expr (s_expr)
  );

`ifdef LOGIC_SWEEP_CHECK_EN
  assign mis_c = (s_gate != s_expr);
`else
  logic unused_expr;
  assign unused_expr = ^s_expr;
  assign mis_c       = 1'b0;
`endif

  // Next state, minterm counter and error count
  always_comb begin
    state_d = state;
    m_d     = m;
    func_d  = func_q;
    valid_d = out_valid;
    done_d  = 1'b0;
    load    = 1'b0;
    err_d   = err_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = '0;
          func_d  = func_t'(func);
          valid_d = 1'b1;
          load    = 1'b1;
          err_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (out_ready) begin
          if (mismatch && (err_count != '1)) err_d = err_count + CNT_W'(1);
          if (m == '1) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            m_d  = m + MW'(1);
            load = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and mismatch only move when a new vector is loaded
  always_comb begin
    s_d   = out_s;
    mis_d = valid_d ? mismatch : 1'b0;
    if (load) begin
      s_d   = s_gate;
      mis_d = mis_c;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      func_q    <= F_AND;
      m         <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_s     <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      func_q    <= func_d;
      m         <= m_d;
      out_valid <= valid_d;
      out_a     <= a_d;
      out_b     <= b_d;
      out_s     <= s_d;
      mismatch  <= mis_d;
      err_count <= err_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/logic_sweep.md
LOGIC_SWEEP -- requirements
Module: logic_sweep

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the mismatch counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-007 SHALL have port func, input, 3 bits: function select, captured on accepted start.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the current vector.
REQ-009 SHALL have port out_valid, output, 1 bit: out_a, out_b and out_s hold a vector.
REQ-010 SHALL have port out_a, output, WIDTH bits: operand a of the current vector.
REQ-011 SHALL have port out_b, output, WIDTH bits: operand b of the current vector.
REQ-012 SHALL have port out_s, output, WIDTH bits: bitwise f(out_a, out_b).
REQ-013 SHALL have port mismatch, output, 1 bit: the gate path and the expression path disagree on the current vector.
REQ-014 SHALL have port err_count, output, CNT_W bits: count of accepted mismatching vectors.
REQ-015 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at normal sweep completion.

Function
REQ-017 SHALL decode func, bitwise, as: 0 AND, 1 OR, 2 a'.b (inhibit), 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 a.b'.
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE with start=1, latch func, clear the minterm counter m (2*WIDTH bits) and err_count, and enter RUN the next cycle.
REQ-020 SHALL, in RUN, drive registered outputs out_valid=1, out_a=m[2W-1:W] and out_b=m[W-1:0], with out_s computed from those same values in the same cycle.
REQ-021 SHALL apply valid/ready handshaking: with out_valid=1 and out_ready=0, all outputs and m hold unchanged.
REQ-022 SHALL, on out_valid=1 and out_ready=1 with m below 2^(2*WIDTH)-1, advance m by 1; the next vector appears the following cycle.
REQ-023 SHALL, on acceptance with m equal to all-ones, enter DONE; in DONE, out_valid=0 and done=1 for exactly one cycle, then IDLE.
REQ-024 SHALL, on abort=1 in RUN or DONE, enter IDLE the next cycle with out_valid=0 and done=0; err_count is retained.
REQ-025 SHALL give abort priority over out_ready when both are high in the same cycle.
REQ-026 SHALL ignore start outside IDLE; a change on func while busy has no effect.
REQ-027 SHALL increment err_count on each accepted vector with mismatch=1, saturating at all-ones.
REQ-028 SHALL hold out_a, out_b and out_s at their last values when out_valid=0.

Reset
REQ-029 SHALL, on rst=1, immediately set state IDLE, m=0, out_valid=0, out_a=0, out_b=0, out_s=0, mismatch=0, err_count=0, busy=0 and done=0, including mid-sweep.

Configuration
REQ-030 SHALL, with LOGIC_SWEEP_CHECK_EN defined, instantiate a second evaluation path built from NAND-only expressions, compare it with the gate path, and drive mismatch and err_count from that comparison.
REQ-031 SHALL, without LOGIC_SWEEP_CHECK_EN, omit the second path and tie mismatch and err_count to 0.

Structure
REQ-032 SHALL place the func_t enumeration (the 8 codes) and the state_t enumeration in the shared package logic_sweep_pkg.
REQ-033 SHALL implement the combinational evaluator as sub-module logic_sweep_core (inputs a, b, func; outputs s_gate, s_expr), instantiated once.

Verification
REQ-034 SHALL test WIDTH=1, func=2, out_ready held 1: out_s sequence 0,1,0,0 for (a,b)=00,01,10,11, then done pulses once.
REQ-035 SHALL test WIDTH=4, func=3: exactly 256 accepted vectors; the vector with out_a=0xA, out_b=0x6 gives out_s=0xC; err_count=0 at done.
REQ-036 SHALL test out_ready low for 5 cycles at m=7: outputs stay frozen at m=7, and m=8 appears one cycle after out_ready returns high.
REQ-037 SHALL test abort asserted at m=20: busy=0 the next cycle, done never pulses, and a following start restarts at m=0.
REQ-038 SHALL test rst pulsed mid-sweep: all outputs are 0 in the same cycle, and start after release begins a fresh sweep.
REQ-039 SHALL test, with LOGIC_SWEEP_CHECK_EN defined and the expression path forced to invert bit 0: every accepted vector sets mismatch, and err_count equals 2^(2W) at done (saturating if CNT_W is smaller).
